// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and the pipeline registers
// that follow it.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT       = 2'd0,
        RUN        = 2'd1,
        HOLD_REDIR = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Signals between the fetch stage, the hazard unit, PC-update logic,
// instruction memory and the decode stage.
interface fetch_stage_if #(
    parameter int IMEM_AW = 6
);
    logic                stall_f;
    logic                flush_d;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic [IMEM_AW-1:0]  imem_addr;
    logic [31:0]         imem_rd;
    logic [31:0]         pc_f;
    logic [31:0]         instr_d;
    logic [31:0]         pc_plus4_d;
    logic                valid_d;
    logic                redir_pend;

    modport master (
        input  stall_f, flush_d, redirect, redirect_pc, imem_rd,
        output imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, redir_pend
    );

    modport slave (
        output stall_f, flush_d, redirect, redirect_pc, imem_rd,
        input  imem_addr, pc_f, instr_d, pc_plus4_d, valid_d, redir_pend
    );
endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats squash, squash beats load.
// A bubble clears instruction, PC+4 and valid together.
module ifid_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        stall,
    input  logic        squash,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic        valid_q,    valid_d;

    always_comb begin
        // NOTE: every output takes its held value first so no path infers a latch.
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush || (!stall && squash)) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, deferred-redirect FSM and IF/ID register.
// A redirect arriving during a stall is parked in pend_pc until the stall releases.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q,      pc_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         squash;

    assign target   = align_pc(bus.redirect_pc);
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        squash    = 1'b0;
        case (state_q)
            BOOT, RUN: begin
                squash = bus.redirect;
                if (bus.stall_f) begin
                    if (bus.redirect) begin
                        pend_pc_d = target;
                        state_d   = HOLD_REDIR;
                    end
                end else begin
                    state_d = RUN;
                    pc_d    = bus.redirect ? target : pc_plus4;
                end
            end
            HOLD_REDIR: begin
                squash = 1'b1;
                if (bus.stall_f) begin
                    if (bus.redirect) pend_pc_d = target;
                end else begin
                    // A redirect in the release cycle is newer than the parked one.
                    pc_d    = bus.redirect ? target : pend_pc_q;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    ifid_reg u_ifid (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (bus.flush_d),
        .stall       (bus.stall_f),
        .squash      (squash),
        .instr_in    (bus.imem_rd),
        .pc_plus4_in (pc_plus4),
        .instr_o     (bus.instr_d),
        .pc_plus4_o  (bus.pc_plus4_d),
        .valid_o     (bus.valid_d)
    );

    assign bus.imem_addr  = pc_q[IMEM_AW+1:2];
    assign bus.pc_f       = pc_q;
    assign bus.redir_pend = (state_q == HOLD_REDIR);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    fetch_stage_if #(.IMEM_AW(6)) bus ();
    fetch_stage_if #(.IMEM_AW(6)) bus_w ();

    assign bus.imem_rd   = mem[bus.imem_addr];
    assign bus_w.imem_rd = mem[bus_w.imem_addr];
    assign bus_w.stall_f     = 1'b0;
    assign bus_w.flush_d     = 1'b0;
    assign bus_w.redirect    = 1'b0;
    assign bus_w.redirect_pc = 32'h0;

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(6)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_AW(6)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
        bus.stall_f     = st;
        bus.flush_d     = fl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
    endtask

    task automatic do_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.redir_pend} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h instr=%h pc4=%h v=%b p=%b, expected all zero",
                     bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.redir_pend);
        end
        checks++;
        if (bus.imem_addr !== 6'd0) begin
            errors++;
            $display("FAIL reset_imem_addr: got %0d expected 0", bus.imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        checks++;
        if ({bus.pc_f, bus.valid_d} !== {32'h0, 1'b0}) begin
            errors++;
            $display("FAIL seq_start: got pc=%h v=%b expected pc=0 v=0", bus.pc_f, bus.valid_d);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d} !==
                {32'(4 * (k + 1)), mem[k], 32'(4 * (k + 1)), 1'b1}) begin
                errors++;
                $display("FAIL seq_%0d: got pc=%h instr=%h pc4=%h v=%b expected pc=%h instr=%h pc4=%h v=1",
                         k, bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d,
                         32'(4 * (k + 1)), mem[k], 32'(4 * (k + 1)));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        tick();
        tick();
        // pc_f is now 8; low target bits must be ignored
        set_in(1'b0, 1'b0, 1'b1, 32'h0000_0043);
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d} !== {32'h40, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL redirect_bubble: got pc=%h instr=%h pc4=%h v=%b expected pc=40 bubble",
                     bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d} !== {32'h44, mem[16], 32'h44, 1'b1}) begin
            errors++;
            $display("FAIL redirect_target: got pc=%h instr=%h pc4=%h v=%b expected pc=44 instr=%h pc4=44 v=1",
                     bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d, mem[16]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (3) tick();
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d} !== {32'hC, mem[2], 32'hC, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc=%h instr=%h pc4=%h expected pc=c instr=%h pc4=c",
                         k, bus.pc_f, bus.instr_d, bus.pc_plus4_d, mem[2]);
            end
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d} !== {32'h10, mem[3], 32'h10}) begin
            errors++;
            $display("FAIL stall_release: got pc=%h instr=%h pc4=%h expected pc=10 instr=%h pc4=10",
                     bus.pc_f, bus.instr_d, bus.pc_plus4_d, mem[3]);
        end
    endtask

    // Runs from pc_f=0x10 with instr_d=mem[3]; second_rd adds a newer redirect mid-hold.
    task automatic test_redirect_stalled(input bit second_rd);
        logic [31:0] exp_pc;
        exp_pc = second_rd ? 32'hA0 : 32'h80;
        do_reset();
        repeat (4) tick();
        set_in(1'b1, 1'b0, 1'b1, 32'h80);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({bus.pc_f, bus.instr_d, bus.valid_d, bus.redir_pend} !== {32'h10, mem[3], 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL hold_%0d_%0d: got pc=%h instr=%h v=%b pend=%b expected pc=10 instr=%h v=1 pend=1",
                         second_rd, k, bus.pc_f, bus.instr_d, bus.valid_d, bus.redir_pend, mem[3]);
            end
            set_in(1'b1, 1'b0, second_rd && (k == 0), 32'hA0);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({bus.pc_f, bus.valid_d, bus.redir_pend} !== {exp_pc, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL hold_release_%0d: got pc=%h v=%b pend=%b expected pc=%h v=0 pend=0",
                     second_rd, bus.pc_f, bus.valid_d, bus.redir_pend, exp_pc);
        end
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.valid_d} !== {exp_pc + 32'd4, mem[exp_pc[7:2]], 1'b1}) begin
            errors++;
            $display("FAIL hold_target_%0d: got pc=%h instr=%h v=%b expected pc=%h instr=%h v=1",
                     second_rd, bus.pc_f, bus.instr_d, bus.valid_d, exp_pc + 32'd4, mem[exp_pc[7:2]]);
        end
    endtask

    task automatic test_flush_with_stall();
        do_reset();
        repeat (2) tick();
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d} !== {32'h8, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL flush_stall: got pc=%h instr=%h pc4=%h v=%b expected pc=8 bubble",
                     bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.valid_d} !== {32'hC, mem[2], 1'b1}) begin
            errors++;
            $display("FAIL flush_resume: got pc=%h instr=%h v=%b expected pc=c instr=%h v=1",
                     bus.pc_f, bus.instr_d, bus.valid_d, mem[2]);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        repeat (3) tick();
        set_in(1'b1, 1'b0, 1'b1, 32'hC0);
        tick();
        checks++;
        if (bus.redir_pend !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pend: got %b expected 1", bus.redir_pend);
        end
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.redir_pend} !==
            {32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_async: got pc=%h instr=%h pc4=%h v=%b p=%b expected all zero",
                     bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.redir_pend);
        end
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({bus.pc_f, bus.instr_d, bus.valid_d, bus.redir_pend} !== {32'h4, mem[0], 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL midreset_no_redirect: got pc=%h instr=%h v=%b p=%b expected pc=4 instr=%h v=1 p=0",
                     bus.pc_f, bus.instr_d, bus.valid_d, bus.redir_pend, mem[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        checks++;
        if ({bus_w.pc_f, bus_w.imem_addr} !== {32'hFFFF_FFFC, 6'd63}) begin
            errors++;
            $display("FAIL wrap_start: got pc=%h addr=%0d expected pc=fffffffc addr=63",
                     bus_w.pc_f, bus_w.imem_addr);
        end
        tick();
        checks++;
        if ({bus_w.pc_f, bus_w.imem_addr, bus_w.instr_d, bus_w.pc_plus4_d, bus_w.valid_d} !==
            {32'h0, 6'd0, mem[63], 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_next: got pc=%h addr=%0d instr=%h pc4=%h v=%b expected pc=0 addr=0 instr=%h pc4=0 v=1",
                     bus_w.pc_f, bus_w.imem_addr, bus_w.instr_d, bus_w.pc_plus4_d, bus_w.valid_d, mem[63]);
        end
    endtask

    // Model: fetch PC, an optional parked redirect target, and the IF/ID contents.
    task automatic test_random();
        logic [31:0] m_pc, m_pend_pc, m_instr, m_pc4, tgt;
        logic        m_pend, m_valid, st, fl, rd;
        logic [31:0] rpc;
        do_reset();
        m_pc = 32'h0; m_pend = 1'b0; m_pend_pc = 32'h0;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            st  = ($urandom_range(99) < 30);
            fl  = ($urandom_range(99) < 10);
            rd  = ($urandom_range(99) < 20);
            rpc = $urandom;
            set_in(st, fl, rd, rpc);
            tgt = {rpc[31:2], 2'b00};
            if (fl || (!st && (m_pend || rd))) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else if (!st) begin
                m_instr = mem[m_pc[7:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (st) begin
                if (rd) begin m_pend = 1'b1; m_pend_pc = tgt; end
            end else if (m_pend) begin
                m_pc = rd ? tgt : m_pend_pc;
                m_pend = 1'b0;
            end else begin
                m_pc = rd ? tgt : m_pc + 32'd4;
            end
            tick();
            checks++;
            if ({bus.pc_f, bus.imem_addr, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.redir_pend} !==
                {m_pc, m_pc[7:2], m_instr, m_pc4, m_valid, m_pend}) begin
                errors++;
                $display("FAIL random_cyc%0d: got pc=%h addr=%0d instr=%h pc4=%h v=%b p=%b expected pc=%h addr=%0d instr=%h pc4=%h v=%b p=%b",
                         cyc, bus.pc_f, bus.imem_addr, bus.instr_d, bus.pc_plus4_d, bus.valid_d, bus.redir_pend,
                         m_pc, m_pc[7:2], m_instr, m_pc4, m_valid, m_pend);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_redirect_stalled(1'b0);
        test_redirect_stalled(1'b1);
        test_flush_with_stall();
        test_reset_mid_hold();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register.
- Consumes the redirect target produced by the PC-update logic (branch/jal/jr) and hazard-unit stall/flush controls.
- Feeds the decode stage (register file read ports, sign extension, control).
- Remembers a redirect that arrives while fetch is stalled and applies it later, so no redirect is ever lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
IMEM_AW, 6, instruction-memory word-address width; imem_addr = pc_f[IMEM_AW+1:2].

Ports:
clk  input  1  core clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
stall_f  input  1  hazard unit: hold PC and IF/ID contents this cycle.
flush_d  input  1  hazard unit: load bubble into IF/ID this cycle.
redirect  input  1  control-flow change taken (branch taken, jal, jr).
redirect_pc  input  32  target from PC-update logic; bits [1:0] forced to 0 internally.
imem_addr  output  IMEM_AW  word address to instruction memory (combinational from pc_f).
imem_rd  input  32  instruction word returned combinationally by instruction memory.
pc_f  output  32  current fetch PC.
instr_d  output  32  IF/ID instruction.
pc_plus4_d  output  32  IF/ID PC+4 (for jal link / branch offset base).
valid_d  output  1  IF/ID holds a real instruction (0 = bubble).
redir_pend  output  1  a redirect is latched and waiting for stall release (debug/verification visibility).

Behaviour:
- Reset (rst_n low, asynchronous): pc_f=RESET_PC, instr_d=NOP (32'h0), pc_plus4_d=0, valid_d=0, redir_pend=0, state=BOOT.
- FSM states:
  - BOOT: the first posedge after reset release fetches at RESET_PC → RUN.
  - RUN: normal fetch.
  - HOLD_REDIR: a redirect was seen while stall_f=1 and is held until the stall releases.
- Transitions:
  - RUN and redirect & stall_f: latch target into pend_pc, redir_pend=1, PC and IF/ID hold → HOLD_REDIR.
  - HOLD_REDIR and stall_f: hold everything. A new redirect overwrites pend_pc (newest wins).
  - HOLD_REDIR and !stall_f: pc_f←pend_pc (or redirect_pc if redirect is high that cycle), IF/ID←bubble, redir_pend=0 → RUN.
- Next-PC priority in RUN and BOOT, highest first:
  - stall_f: hold.
  - redirect: pc_f←{redirect_pc[31:2],2'b00}.
  - otherwise: pc_f←pc_f+4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0. imem_addr wraps every 2^IMEM_AW words by truncation.
- IF/ID update priority, highest first:
  - flush_d: instr_d←NOP, valid_d←0, pc_plus4_d←0.
  - stall_f: hold.
  - redirect: the wrong-path word is squashed, giving a bubble.
  - otherwise: instr_d←imem_rd, pc_plus4_d←pc_f+4, valid_d←1.
- flush_d together with stall_f: flush wins for IF/ID; PC still holds.
- Latency:
  - instruction at PC X appears on instr_d one cycle after pc_f==X with no stall.
  - redirect penalty is one bubble.
- imem_addr is purely combinational from pc_f; no registered read.
- Reset asserted mid-operation (any state, including HOLD_REDIR) discards the pending redirect immediately.

Decomposition:
- Shared package holds: NOP_INSTR=32'h0, RESET_PC default, FSM state encoding (BOOT=2'd0, RUN=2'd1, HOLD_REDIR=2'd2).
- One natural sub-module, ifid_reg: the IF/ID pipeline register with flush/stall priority, reused by later stage registers.
- The PC register, pend_pc and the FSM stay in fetch_stage.

Test Plan:
- Reset release, no stalls: pc_f sequence 0,4,8,C. instr_d = imem words 0,1,2 starting the cycle after pc_f=0; valid_d 0 then 1.
- Redirect at pc_f=8 with redirect_pc=32'h40: next pc_f=40; instr_d is bubble (valid_d=0) for one cycle, then word 16.
- stall_f high for 3 cycles at pc_f=C: pc_f, instr_d and pc_plus4_d unchanged for 3 cycles, then pc_f=10.
- redirect (target 32'h80) while stall_f=1, stall held 2 more cycles: redir_pend=1 throughout, PC held. On release pc_f=80, valid_d=0, redir_pend=0.
- Same as previous, but a second redirect (target 32'hA0) arrives during the hold: pc_f=A0 on release (newest wins).
- Wrap, and reset mid-hold:
  - RESET_PC=32'hFFFF_FFFC: pc_f goes to 0 next cycle; imem_addr goes from 63 to 0.
  - rst_n pulsed low in HOLD_REDIR: outputs return to reset values asynchronously, and no redirect is applied afterward.
